// File: rtl/delay_counter_if.sv
// Control/status bundle for delay_counter_param: run/load/mode in, count and strobes out.
interface delay_counter_if #(
  parameter int unsigned WIDTH = 16
);
  logic             run;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             periodic;
  logic [WIDTH-1:0] count;
  logic             counted;
  logic             expired;

  modport master (
    output run, load, load_value, periodic,
    input  count, counted, expired
  );

  modport slave (
    input  run, load, load_value, periodic,
    output count, counted, expired
  );
endinterface

// File: rtl/delay_counter_param.sv
// Reloadable down-counting delay timer with one-shot/periodic modes and expiry strobe.
// Optional prescaler enabled by defining DELAY_COUNTER_PRESCALE_EN.
module delay_counter_param #(
  parameter int unsigned      WIDTH        = 16,
  parameter logic [WIDTH-1:0] DEFAULT_LOAD = WIDTH'(10),
  parameter int unsigned      PRESCALE_DIV = 4
) (
  input logic             tick,
  input logic             clear,
  delay_counter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StCount, StDone} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_counted;
  logic             r_expired;

  logic [WIDTH-1:0] w_reload_next;
  logic             w_step;

  // A load coinciding with a reload point takes effect for that reload.
  assign w_reload_next = bus.load ? bus.load_value : r_reload;

`ifdef DELAY_COUNTER_PRESCALE_EN
  localparam int unsigned DivW = (PRESCALE_DIV > 2) ? $clog2(PRESCALE_DIV) : 1;

  logic [DivW-1:0] r_div;

  assign w_step = (r_div == DivW'(PRESCALE_DIV - 1));
`else
  assign w_step = 1'b1;
`endif

  always_ff @(posedge tick) begin
    if (clear) begin
      r_state   <= StIdle;
      r_count   <= DEFAULT_LOAD;
      r_reload  <= DEFAULT_LOAD;
      r_counted <= 1'b0;
      r_expired <= 1'b0;
`ifdef DELAY_COUNTER_PRESCALE_EN
      r_div     <= '0;
`endif
    end else begin
      r_reload  <= w_reload_next;
      r_expired <= 1'b0;

      unique case (r_state)
        StIdle: begin
          r_count   <= w_reload_next;
          r_counted <= 1'b0;
          if (bus.run) begin
            r_state <= StCount;
          end
        end

        StCount: begin
          if (!bus.run) begin
            r_state <= StIdle;
            r_count <= w_reload_next;
          end else if (w_step) begin
            // A zero reload also lands here, so the count never wraps.
            if (r_count <= WIDTH'(1)) begin
              r_state   <= StDone;
              r_count   <= '0;
              r_counted <= 1'b1;
              r_expired <= 1'b1;
            end else begin
              r_count <= r_count - WIDTH'(1);
            end
          end
        end

        StDone: begin
          if (!bus.run) begin
            r_state   <= StIdle;
            r_count   <= w_reload_next;
            r_counted <= 1'b0;
          end else if (bus.periodic) begin
            r_state   <= StCount;
            r_count   <= w_reload_next;
            r_counted <= 1'b0;
          end
        end

        default: begin
          r_state   <= StIdle;
          r_count   <= w_reload_next;
          r_counted <= 1'b0;
        end
      endcase

`ifdef DELAY_COUNTER_PRESCALE_EN
      // Divider only runs while counting; any other state or a step zeroes it.
      if (r_state == StCount && bus.run && !w_step) begin
        r_div <= r_div + DivW'(1);
      end else begin
        r_div <= '0;
      end
`endif
    end
  end

  assign bus.count   = r_count;
  assign bus.counted = r_counted;
  assign bus.expired = r_expired;

endmodule
